// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8N1 serial transmitter with a small byte FIFO in front of it.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high
//   tx_en      - one-cycle write strobe; tx_data is enqueued on this edge
//   tx_data    - byte to transmit
//   ovf_clr    - clears the sticky overflow flag
//   tx         - serial line, idle high, registered
//   busy       - frame in progress or FIFO non-empty (registered)
//   fifo_full  - FIFO holds FIFO_DEPTH entries
//   overflow   - sticky; set when a write is dropped on a full FIFO
module uart_tx_unit #(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BaudW = $clog2(BAUD_DIV);

  localparam logic [CntW-1:0]  FullCnt  = CntW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [BaudW-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  logic fifo_empty, full, baud_done, pop, push_ok, ovf_set;

  always_comb begin
    fifo_empty = (count_q == '0);
    full       = (count_q == FullCnt);
    baud_done  = (baud_cnt_q == BaudLast);

    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + BaudW'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          state_d    = StData;
          tx_d       = shift_q[0];
          bit_idx_d  = '0;
        end
      end
      StData: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit: no idle gap.
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    push_ok = tx_en && (!full || pop);
    ovf_set = tx_en && full && !pop;
    count_d = count_q + CntW'(push_ok) - CntW'(pop);
    busy_d  = (state_d != StIdle) || (count_d != '0);
    // Set wins over clear.
    ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= tx_data;
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign fifo_full = (count_q == FullCnt);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
module tb_uart_tx_unit;
  localparam int B = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset, tx_en, ovf_clr;
  logic [7:0] tx_data;
  logic       tx, busy, fifo_full, overflow;

  uart_tx_unit #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .ovf_clr  (ovf_clr),
    .tx       (tx),
    .busy     (busy),
    .fifo_full(fifo_full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Reference model: queue of waiting bytes plus the start time of the frame on the wire.
  byte unsigned m_q[$];
  byte unsigned m_sent[$];
  bit           m_active = 1'b0;
  int           m_start  = 0;
  byte unsigned m_byte   = 8'h00;
  bit           m_ovf    = 1'b0;

  // Line decoder: samples tx mid-bit and collects received bytes.
  bit           rx_busy = 1'b0;
  int           rx_cnt  = 0;
  byte unsigned rx_byte = 8'h00;
  byte unsigned rx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_tx();
    int bit_i;
    if (!m_active) return 1'b1;
    bit_i = (n - m_start) / B;
    if (bit_i == 0) return 1'b0;
    if (bit_i >= 9) return 1'b1;
    return m_byte[bit_i-1];
  endfunction

  task automatic model_edge(input bit en, input byte unsigned d, input bit clr, input bit rst);
    bit set;
    n++;
    set = 1'b0;
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
      return;
    end
    if (m_active && n == m_start + 10 * B) m_active = 1'b0;
    if (!m_active && m_q.size() > 0) begin
      m_byte   = m_q.pop_front();
      m_active = 1'b1;
      m_start  = n;
      m_sent.push_back(m_byte);
    end
    if (en) begin
      if (m_q.size() < D) m_q.push_back(d);
      else set = 1'b1;
    end
    if (set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic rx_sample();
    int idx;
    if (!rx_busy) begin
      if (tx == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
        rx_byte = 8'h00;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % B == B / 2) begin
        idx = rx_cnt / B;
        if (idx >= 1 && idx <= 8) rx_byte[idx-1] = tx;
        else if (idx == 9) begin
          chk("stop_bit", tx, 1);
          rx_q.push_back(rx_byte);
          rx_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle(input bit en = 0, input byte unsigned d = 0, input bit clr = 0,
                       input bit rst = 0);
    tx_en   = en;
    tx_data = d;
    ovf_clr = clr;
    reset   = rst;
    @(posedge clk);
    model_edge(en, d, clr, rst);
    #1;
    chk("tx", tx, model_tx());
    chk("busy", busy, (m_active || m_q.size() > 0));
    chk("fifo_full", fifo_full, (m_q.size() == D));
    chk("overflow", overflow, m_ovf);
    if (rst) rx_busy = 1'b0;
    else rx_sample();
  endtask

  initial begin
    int k;
    int guard;
    int lim;
    tx_en = 0; tx_data = 0; ovf_clr = 0; reset = 1;

    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);

    // 1: single byte 0x55 gives alternating levels, 4 cycles each.
    cycle(1, 8'h55);
    k = n;
    chk("t1_busy_rise", busy, 1);
    for (int i = 0; i < 40; i++) begin
      cycle();
      chk("t1_level", tx, (i / 4) % 2);
    end
    cycle();
    chk("t1_busy_low", busy, 0);
    chk("t1_at_k41", n - k, 41);
    chk("t1_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("t1_rx_byte", rx_q[0], 8'h55);

    // 2: back-to-back frames.
    rx_q.delete();
    cycle(1, 8'hA3);
    cycle(1, 8'h0F);
    repeat (85) cycle();
    chk("t2_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("t2_rx_0", rx_q[0], 8'hA3);
      chk("t2_rx_1", rx_q[1], 8'h0F);
    end
    chk("t2_overflow", overflow, 0);

    // 3: six writes from idle, sixth is dropped.
    rx_q.delete();
    for (int i = 1; i <= 6; i++) begin
      cycle(1, 8'(i));
      if (i == 5) chk("t3_full", fifo_full, 1);
      if (i == 6) chk("t3_overflow", overflow, 1);
    end
    repeat (5 * 10 * B + 10) cycle();
    chk("t3_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("t3_rx_byte", rx_q[i], i + 1);

    // 4: clear overflow; clear coinciding with a dropped write keeps it set.
    rx_q.delete();
    cycle(0, 0, 1);
    chk("t4_clr", overflow, 0);
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h30 + i));
    chk("t4_full", fifo_full, 1);
    cycle(1, 8'h3F, 1);
    chk("t4_set_wins", overflow, 1);

    // 5: push coinciding with the stop-bit-end pop on a full FIFO.
    cycle(0, 0, 1);
    chk("t5_clr", overflow, 0);
    guard = 0;
    while (!(m_active && n + 1 == m_start + 10 * B) && guard < 100) begin
      cycle();
      guard++;
    end
    chk("t5_wait_bound", (guard < 100), 1);
    chk("t5_full_before", fifo_full, 1);
    cycle(1, 8'h77);
    chk("t5_full_after", fifo_full, 1);
    chk("t5_no_ovf", overflow, 0);
    repeat (6 * 10 * B + 20) cycle();
    chk("t5_rx_count", rx_q.size(), 6);
    if (rx_q.size() == 6) chk("t5_last", rx_q[5], 8'h77);

    // 6: reset mid-DATA with two bytes queued.
    rx_q.delete();
    cycle(1, 8'hC3);
    cycle(1, 8'h11);
    cycle(1, 8'h22);
    repeat (12) cycle();
    cycle(0, 0, 0, 1);
    chk("t6_tx", tx, 1);
    chk("t6_busy", busy, 0);
    chk("t6_full", fifo_full, 0);
    repeat (100) cycle();
    chk("t6_no_frames", rx_q.size(), 0);
    chk("t6_idle", tx, 1);

    // Random traffic against the model.
    m_sent.delete();
    rx_q.delete();
    for (int i = 0; i < 800; i++)
      cycle(($urandom_range(0, 9) == 0), 8'($urandom), ($urandom_range(0, 19) == 0));
    repeat ((D + 1) * 10 * B + 20) cycle();
    chk("rnd_count", rx_q.size(), m_sent.size());
    lim = (rx_q.size() < m_sent.size()) ? rx_q.size() : m_sent.size();
    for (int i = 0; i < lim; i++) chk("rnd_byte", rx_q[i], m_sent[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
